// File: rtl/obstacle_one_renderer.sv
// rtl/obstacle_one_renderer.sv - scrolling obstacle sprite reader with 3-edge pixel pipeline
// Optional collision flag enabled by `define OBSTACLE_COLLISION_EN.
module obstacle_one_renderer #(
  parameter int          ADDR_WIDTH = 10,
  parameter int          DATA_WIDTH = 2,
  parameter int          H_RES      = 640,
  parameter logic [11:0] COLOR1     = 12'hF00,
  parameter logic [11:0] COLOR2     = 12'h0F0,
  parameter logic [11:0] COLOR3     = 12'hFFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [10:0]           x,
  input  logic [10:0]           y,
  input  logic [10:0]           oy,
  input  logic                  frame_tick,
  input  logic                  start,
  input  logic                  stop,
  input  logic [3:0]            speed,
  output logic [ADDR_WIDTH-1:0] ram_addr_r,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [11:0]           rgb_out,
  output logic                  sprite_on,
  output logic                  running,
`ifdef OBSTACLE_COLLISION_EN
  input  logic                  player_on,
  output logic                  collision,
`endif
  output logic [7:0]            pass_count
);

  localparam int          HALF = ADDR_WIDTH / 2;
  localparam logic [11:0] SIDE = 12'(1 << HALF);
  localparam logic [11:0] HRES = 12'(H_RES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [11:0] ox_q, ox_d;
  logic [7:0]  pc_q, pc_d;
  logic        in_box, in_box_d1, in_box_d2;
  logic [11:0] x12, y12, oy12, speed12;
  logic [HALF-1:0] col, row;
  logic [11:0] rgb_d;
  logic        on_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ox_q    <= HRES;
      pc_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      ox_q    <= ox_d;
      pc_q    <= pc_d;
    end
  end

  // stop beats start; start beats a same-cycle frame_tick
  always_comb begin
    state_d = state_q;
    ox_d    = ox_q;
    pc_d    = pc_q;
    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      state_d = RUN;
      ox_d    = HRES;
    end else if (frame_tick && state_q == RUN) begin
      if (ox_q >= speed12) begin
        ox_d = ox_q - speed12;
      end else begin
        ox_d = HRES;
        if (pc_q != 8'hFF) pc_d = pc_q + 8'd1;
      end
    end
  end

  assign running    = (state_q == RUN);
  assign pass_count = pc_q;

  assign x12     = {1'b0, x};
  assign y12     = {1'b0, y};
  assign oy12    = {1'b0, oy};
  assign speed12 = {8'd0, speed};
  assign in_box  = (x12 >= ox_q) && (x12 < ox_q + SIDE) &&
                   (y12 >= oy12) && (y12 < oy12 + SIDE);
  assign col     = HALF'(x12 - ox_q);
  assign row     = HALF'(y12 - oy12);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_addr_r <= '0;
      in_box_d1  <= 1'b0;
      in_box_d2  <= 1'b0;
    end else begin
      if (in_box) ram_addr_r <= {row, col};
      in_box_d1 <= in_box;
      in_box_d2 <= in_box_d1;
    end
  end

  always_comb begin
    rgb_d = 12'h000;
    on_d  = 1'b0;
    if (in_box_d2) begin
      if (ram_dout == DATA_WIDTH'(1)) begin
        rgb_d = COLOR1;
        on_d  = 1'b1;
      end else if (ram_dout == DATA_WIDTH'(2)) begin
        rgb_d = COLOR2;
        on_d  = 1'b1;
      end else if (ram_dout == DATA_WIDTH'(3)) begin
        rgb_d = COLOR3;
        on_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_out   <= 12'h000;
      sprite_on <= 1'b0;
    end else begin
      rgb_out   <= rgb_d;
      sprite_on <= on_d;
    end
  end

`ifdef OBSTACLE_COLLISION_EN
  // sticky hit flag; a same-cycle set outranks the clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    collision <= 1'b0;
    else if (on_d && player_on)   collision <= 1'b1;
    else if (frame_tick || start) collision <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_obstacle_one_renderer.sv
// tb/tb_obstacle_one_renderer.sv - randomized bench with behavioural reference model
module tb_obstacle_one_renderer;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] x, y, oy;
  logic        frame_tick, start, stop;
  logic [3:0]  speed;
  logic [9:0]  ram_addr_r;
  logic [1:0]  ram_dout;
  logic [11:0] rgb_out;
  logic        sprite_on, running;
  logic [7:0]  pass_count;
  logic        player_on;
`ifdef OBSTACLE_COLLISION_EN
  logic        collision;
`endif

  obstacle_one_renderer dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .oy(oy),
    .frame_tick(frame_tick), .start(start), .stop(stop), .speed(speed),
    .ram_addr_r(ram_addr_r), .ram_dout(ram_dout), .rgb_out(rgb_out),
    .sprite_on(sprite_on), .running(running),
`ifdef OBSTACLE_COLLISION_EN
    .player_on(player_on), .collision(collision),
`endif
    .pass_count(pass_count)
  );

  always #5 clk = ~clk;

  logic [1:0] mem [1024];
  always @(posedge clk) ram_dout <= mem[ram_addr_r];

  int checks = 0;
  int errors = 0;

  int m_ox, m_pc, m_addr;
  bit m_run, m_col;
  logic [11:0] q_rgb[$];
  bit          q_on[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] pal(input int code);
    case (code)
      1: return 12'hF00;
      2: return 12'h0F0;
      3: return 12'hFFF;
      default: return 12'h000;
    endcase
  endfunction

  task automatic step();
    int xi, yi, oyi, code;
    bit inb, on;
    logic [11:0] rgb;
    xi = int'(x); yi = int'(y); oyi = int'(oy);
    inb = (xi >= m_ox) && (xi < m_ox + 32) && (yi >= oyi) && (yi < oyi + 32);
    rgb = 12'h000; on = 0;
    if (inb) begin
      m_addr = (yi - oyi) * 32 + (xi - m_ox);
      code = int'(mem[m_addr]);
      if (code != 0) begin on = 1; rgb = pal(code); end
    end
    q_rgb.push_back(rgb);
    q_on.push_back(on);
    if (q_on[0] && player_on) m_col = 1;
    else if (frame_tick || start) m_col = 0;
    if (stop) m_run = 0;
    else if (start) begin m_run = 1; m_ox = 640; end
    else if (frame_tick && m_run) begin
      if (m_ox >= int'(speed)) m_ox = m_ox - int'(speed);
      else begin m_ox = 640; if (m_pc < 255) m_pc++; end
    end
    @(posedge clk); #1;
    start = 0; stop = 0; frame_tick = 0;
    chk("ram_addr_r", 32'(ram_addr_r), 32'(m_addr));
    chk("running", 32'(running), 32'(m_run));
    chk("pass_count", 32'(pass_count), 32'(m_pc));
    chk("rgb_out", 32'(rgb_out), 32'(q_rgb[0]));
    chk("sprite_on", 32'(sprite_on), 32'(q_on[0]));
`ifdef OBSTACLE_COLLISION_EN
    chk("collision", 32'(collision), 32'(m_col));
`endif
    void'(q_rgb.pop_front());
    void'(q_on.pop_front());
  endtask

  task automatic do_reset();
    reset = 1; start = 0; stop = 0; frame_tick = 0; player_on = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_ox = 640; m_pc = 0; m_addr = 0; m_run = 0; m_col = 0;
    q_rgb = {12'h000, 12'h000};
    q_on  = {1'b0, 1'b0};
    chk("reset running", 32'(running), 32'd0);
    chk("reset pass_count", 32'(pass_count), 32'd0);
    chk("reset ram_addr_r", 32'(ram_addr_r), 32'd0);
    chk("reset rgb_out", 32'(rgb_out), 32'd0);
    chk("reset sprite_on", 32'(sprite_on), 32'd0);
`ifdef OBSTACLE_COLLISION_EN
    chk("reset collision", 32'(collision), 32'd0);
`endif
    reset = 0;
  endtask

  task automatic pix(input int xi, input int yi);
    x = 11'(xi); y = 11'(yi);
    step();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 2'($urandom_range(0, 3));
    x = 0; y = 0; oy = 100; speed = 0;
    do_reset();

    // start, then a full-line scan with the obstacle parked at the right edge
    start = 1; step();
    chk("running after start", 32'(running), 32'd1);
    for (int i = 0; i < 640; i++) pix(i, 100 + (i % 40));

    // speed 4, ten frames: ox 600
    start = 1; step();
    speed = 4;
    for (int i = 0; i < 10; i++) begin frame_tick = 1; step(); end
    pix(600, 100);
    chk("addr at box origin", 32'(ram_addr_r), 32'd0);
    pix(631, 131);
    chk("addr at box corner", 32'(ram_addr_r), 32'd1023);
    mem[33] = 2'd2;
    mem[34] = 2'd0;
    pix(601, 101);
    pix(602, 101);
    pix(0, 0);
    chk("code2 rgb", 32'(rgb_out), 32'h0F0);
    chk("code2 sprite_on", 32'(sprite_on), 32'd1);
    pix(0, 0);
    chk("code0 rgb", 32'(rgb_out), 32'h000);
    chk("code0 sprite_on", 32'(sprite_on), 32'd0);

    // drive ox to 3, then an exit with speed 5
    start = 1; step();
    speed = 13;
    for (int i = 0; i < 49; i++) begin frame_tick = 1; step(); end
    pix(5, 101);
    chk("addr at ox=3", 32'(ram_addr_r), 32'd34);
    speed = 5; frame_tick = 1; step();
    chk("first exit count", 32'(pass_count), 32'd1);
    pix(640, 100);
    chk("addr after respawn", 32'(ram_addr_r), 32'd0);

    // start+stop together, then a tick while idle
    start = 1; stop = 1; step();
    chk("stop wins", 32'(running), 32'd0);
    frame_tick = 1; step();
    pix(641, 100);
    chk("idle ox held", 32'(ram_addr_r), 32'd1);

    // saturate pass_count
    start = 1; step();
    speed = 15;
    for (int i = 0; i < 260 * 43; i++) begin
      frame_tick = 1;
      x = 11'(m_ox + $urandom_range(0, 35));
      y = 11'(100 + $urandom_range(0, 35));
      player_on = 1'($urandom_range(0, 1));
      step();
    end
    chk("pass_count saturated", 32'(pass_count), 32'd255);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset();
      if ($urandom_range(0, 15) == 0) oy = 11'($urandom_range(0, 1000));
      if ($urandom_range(0, 9) == 0) x = 11'($urandom_range(0, 2047));
      else x = 11'(m_ox - 4 + $urandom_range(0, 40));
      y = 11'(int'(oy) + $urandom_range(0, 36) - ((oy >= 2) ? 2 : 0));
      speed = 4'($urandom_range(0, 15));
      start = ($urandom_range(0, 63) == 0);
      stop = ($urandom_range(0, 79) == 0);
      frame_tick = !start && ($urandom_range(0, 5) == 0);
      player_on = 1'($urandom_range(0, 1));
      step();
    end

`ifdef OBSTACLE_COLLISION_EN
    // opaque pixel with player_on sets the flag until the next frame_tick
    mem[0] = 2'd3;
    start = 1; player_on = 0; step();
    pix(640, int'(oy));
    pix(0, 0);
    player_on = 1; pix(0, 0);
    chk("collision set", 32'(collision), 32'd1);
    player_on = 0; pix(0, 0);
    chk("collision sticky", 32'(collision), 32'd1);
    speed = 0; frame_tick = 1; pix(0, 0);
    chk("collision cleared", 32'(collision), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
